// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Imported by the interface, the grant picker and the arbiter top.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the arbiter.
// slave = arbiter side; master = requesters plus memory driving the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
);

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;
  logic              err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy, owner, err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy, owner, err
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Two-requester grant picker: fixed priority (LSU wins) or round-robin
// against the last granted requester. Purely combinational.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (ifu_valid && lsu_valid) begin
      // On a tie round-robin favours whoever was not served last.
      if ((ARB_MODE == ARB_RR) && (last_grant == OWN_LSU)) begin
        gnt_ifu = 1'b1;
      end else begin
        gnt_lsu = 1'b1;
      end
    end else begin
      gnt_ifu = ifu_valid;
      gnt_lsu = lsu_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory slave between instruction fetch and load/store with a
// single outstanding transaction and a watchdog that aborts hung accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MASK_W   = 8,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT  = 256
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic              gnt_ifu, gnt_lsu;
  logic              ifu_ready, lsu_ready, req_valid;
  logic              resp_fire, abort, wd_expire;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_ifu, resp_lsu;

  mem_arb_pick #(
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .last_grant (last_grant_q),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wd_cnt_d     = wd_cnt_q;
    ifu_ready    = 1'b0;
    lsu_ready    = 1'b0;
    req_valid    = 1'b0;
    resp_fire    = 1'b0;
    resp_rdata   = '0;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        ifu_ready = gnt_ifu;
        lsu_ready = gnt_lsu;
        if (bus.lsu_req_valid && gnt_lsu) begin
          addr_d       = bus.lsu_addr;
          wen_d        = bus.lsu_wen;
          wdata_d      = bus.lsu_wdata;
          wmask_d      = bus.lsu_wmask;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          wd_cnt_d     = '0;
          state_d      = REQ;
        end else if (bus.ifu_req_valid && gnt_ifu) begin
          addr_d       = bus.ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          wd_cnt_d     = '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        wd_cnt_d  = wd_cnt_q + WD_W'(1);
        if (wd_expire) begin
          resp_fire = 1'b1;
          abort     = 1'b1;
          state_d   = IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        // A genuine response beats a watchdog expiry in the same cycle.
        if (bus.mem_resp_valid) begin
          resp_fire  = 1'b1;
          resp_rdata = bus.mem_rdata;
          state_d    = IDLE;
        end else if (wd_expire) begin
          resp_fire = 1'b1;
          abort     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ifu_ready = 1'b0;
      lsu_ready = 1'b0;
      req_valid = 1'b0;
      resp_fire = 1'b0;
      abort     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign resp_ifu = resp_fire && (owner_q == OWN_IFU);
  assign resp_lsu = resp_fire && (owner_q == OWN_LSU);

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = resp_ifu;
  assign bus.ifu_rdata      = resp_ifu ? resp_rdata : '0;
  assign bus.lsu_resp_valid = resp_lsu;
  assign bus.lsu_rdata      = resp_lsu ? resp_rdata : '0;

  assign bus.mem_req_valid  = req_valid;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  assign bus.busy           = (state_q != IDLE);
  assign bus.owner          = owner_q;
  assign bus.err            = abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin arbiter see identical
// stimulus; a negedge monitor checks probes and responses against queues.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int S_IFU_RDY = 0, S_LSU_RDY = 1, S_MREQ_V = 2, S_MADDR = 3,
                 S_MWEN = 4, S_MWDATA = 5, S_MWMASK = 6, S_BUSY = 7,
                 S_OWNER = 8, S_IFU_RV = 9, S_LSU_RV = 10, S_ERR = 11,
                 S_IFU_RD = 12, S_LSU_RD = 13, NSEL = 14;

  typedef struct {
    string       name;
    int          inst;
    int          sel;
    logic [31:0] exp;
  } probe_t;

  typedef struct packed {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk, rst;
  logic        ifu_req_valid, lsu_req_valid, lsu_wen;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] obs [2][NSEL];
  logic        done;

  probe_t probe_q[$];
  resp_t  exp_q [2][$];
  int     n_chk, n_fail, mcyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter_if bus ();
    assign bus.ifu_req_valid  = ifu_req_valid;
    assign bus.ifu_addr       = ifu_addr;
    assign bus.lsu_req_valid  = lsu_req_valid;
    assign bus.lsu_addr       = lsu_addr;
    assign bus.lsu_wen        = lsu_wen;
    assign bus.lsu_wdata      = lsu_wdata;
    assign bus.lsu_wmask      = lsu_wmask;
    assign bus.mem_req_ready  = mem_req_ready;
    assign bus.mem_resp_valid = mem_resp_valid;
    assign bus.mem_rdata      = mem_rdata;

    mem_arbiter #(.ARB_MODE(gi), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign obs[gi][S_IFU_RDY] = 32'(bus.ifu_req_ready);
    assign obs[gi][S_LSU_RDY] = 32'(bus.lsu_req_ready);
    assign obs[gi][S_MREQ_V]  = 32'(bus.mem_req_valid);
    assign obs[gi][S_MADDR]   = bus.mem_addr;
    assign obs[gi][S_MWEN]    = 32'(bus.mem_wen);
    assign obs[gi][S_MWDATA]  = bus.mem_wdata;
    assign obs[gi][S_MWMASK]  = 32'(bus.mem_wmask);
    assign obs[gi][S_BUSY]    = 32'(bus.busy);
    assign obs[gi][S_OWNER]   = 32'(bus.owner);
    assign obs[gi][S_IFU_RV]  = 32'(bus.ifu_resp_valid);
    assign obs[gi][S_LSU_RV]  = 32'(bus.lsu_resp_valid);
    assign obs[gi][S_ERR]     = 32'(bus.err);
    assign obs[gi][S_IFU_RD]  = bus.ifu_rdata;
    assign obs[gi][S_LSU_RD]  = bus.lsu_rdata;
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", name, k, act, exp);
    end
  endtask

  // Monitor: the only process that compares and counts.
  initial begin
    n_chk = 0;
    n_fail = 0;
    mcyc = 0;
  end

  always @(negedge clk) begin
    probe_t p;
    resp_t  e;
    logic   rv_i, rv_l, er_v;
    mcyc++;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      check(p.name, p.inst, obs[p.inst][p.sel], p.exp);
    end
    for (int k = 0; k < 2; k++) begin
      rv_i = obs[k][S_IFU_RV][0];
      rv_l = obs[k][S_LSU_RV][0];
      er_v = obs[k][S_ERR][0];
      if (rv_i || rv_l || er_v) begin
        if (exp_q[k].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp dut%0d: got ifu_rv=%0b lsu_rv=%0b err=%0b, expected none",
                   k, rv_i, rv_l, er_v);
        end else begin
          e = exp_q[k].pop_front();
          $display("resp dut%0d ifu_rv=%0b lsu_rv=%0b rdata=0x%08h err=%0b", k, rv_i, rv_l,
                   rv_l ? obs[k][S_LSU_RD] : obs[k][S_IFU_RD], er_v);
          check("resp_onehot", k, 32'(rv_i) + 32'(rv_l), 32'd1);
          check("resp_owner", k, 32'(rv_l), 32'(e.who));
          check("resp_rdata", k, rv_l ? obs[k][S_LSU_RD] : obs[k][S_IFU_RD], e.rdata);
          check("resp_err", k, 32'(er_v), 32'(e.err));
        end
      end
      if (!rv_i) check("ifu_rdata_quiet", k, obs[k][S_IFU_RD], 32'd0);
      if (!rv_l) check("lsu_rdata_quiet", k, obs[k][S_LSU_RD], 32'd0);
    end
    if (done || mcyc > 3000) begin
      if (!done) begin
        n_chk++;
        n_fail++;
        $display("FAIL sim_budget: got %0d cycles, expected stimulus to finish", mcyc);
      end
      for (int k = 0; k < 2; k++) check("resp_q_drained", k, 32'(exp_q[k].size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pr(input int k, input int sel, input logic [31:0] exp, input string name);
    probe_t p;
    p.name = name;
    p.inst = k;
    p.sel  = sel;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic pr2(input int sel, input logic [31:0] exp, input string name);
    pr(0, sel, exp, name);
    pr(1, sel, exp, name);
  endtask

  task automatic er(input int k, input logic who, input logic [31:0] rd, input logic e);
    exp_q[k].push_back('{who: who, rdata: rd, err: e});
  endtask

  task automatic er2(input logic who, input logic [31:0] rd, input logic e);
    er(0, who, rd, e);
    er(1, who, rd, e);
  endtask

  initial begin
    done = 1'b0;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    tick();
    tick();

    // Requests during reset must not be accepted
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_resp_valid = 1'b1;
    pr2(S_IFU_RDY, 0, "rst_ifu_rdy"); pr2(S_LSU_RDY, 0, "rst_lsu_rdy");
    pr2(S_MREQ_V, 0, "rst_mreq_v"); pr2(S_BUSY, 0, "rst_busy");
    tick();
    rst = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
    pr2(S_BUSY, 0, "reset_busy"); pr2(S_OWNER, 0, "reset_owner"); pr2(S_MADDR, 0, "reset_maddr");
    pr2(S_MWEN, 0, "reset_mwen"); pr2(S_MWDATA, 0, "reset_mwdata"); pr2(S_MWMASK, 0, "reset_mwmask");
    pr2(S_ERR, 0, "reset_err");
    tick();

    // IFU-only read, memory always ready and responding
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0297;
    pr2(S_IFU_RDY, 1, "rd_ifu_rdy_c0"); pr2(S_LSU_RDY, 0, "rd_lsu_rdy_c0");
    pr2(S_MREQ_V, 0, "rd_mreq_c0"); pr2(S_IFU_RV, 0, "rd_rv_c0");
    tick();
    ifu_req_valid = 1'b0;
    pr2(S_MREQ_V, 1, "rd_mreq_c1"); pr2(S_MADDR, 32'h8000_0000, "rd_maddr_c1");
    pr2(S_MWEN, 0, "rd_mwen_c1"); pr2(S_BUSY, 1, "rd_busy_c1");
    pr2(S_IFU_RV, 0, "rd_rv_c1"); pr2(S_IFU_RDY, 0, "rd_ifu_rdy_c1");
    tick();
    pr2(S_IFU_RV, 1, "rd_rv_c2"); pr2(S_LSU_RV, 0, "rd_lsu_rv_c2"); pr2(S_MREQ_V, 0, "rd_mreq_c2");
    er2(1'b0, 32'h0000_0297, 1'b0);
    tick();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    pr2(S_BUSY, 0, "rd_busy_c3"); pr2(S_OWNER, 0, "rd_owner_c3"); pr2(S_IFU_RV, 0, "rd_rv_c3");
    tick();

    // Both requesters held valid for three transactions
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h100; lsu_addr = 32'h200;
    lsu_wen = 1'b0; mem_req_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      mem_resp_valid = 1'b0;
      pr(0, S_LSU_RDY, 1, "tie_lsu_rdy"); pr(0, S_IFU_RDY, 0, "tie_ifu_rdy");
      pr(1, S_LSU_RDY, 32'(t != 1), "tie_lsu_rdy"); pr(1, S_IFU_RDY, 32'(t == 1), "tie_ifu_rdy");
      tick();
      pr(0, S_OWNER, 1, "tie_owner"); pr(1, S_OWNER, 32'(t != 1), "tie_owner");
      pr(0, S_MADDR, 32'h200, "tie_maddr"); pr(1, S_MADDR, (t == 1) ? 32'h100 : 32'h200, "tie_maddr");
      pr2(S_IFU_RDY, 0, "tie_ifu_rdy_req"); pr2(S_LSU_RDY, 0, "tie_lsu_rdy_req");
      tick();
      mem_resp_valid = 1'b1; mem_rdata = 32'h1000 + t;
      er(0, 1'b1, 32'h1000 + t, 1'b0);
      er(1, (t == 1) ? 1'b0 : 1'b1, 32'h1000 + t, 1'b0);
      pr(0, S_IFU_RDY, 0, "tie_ifu_rdy_resp");
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    tick();

    // Store with memory stalling the request for four cycles
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    pr2(S_LSU_RDY, 1, "st_lsu_rdy");
    tick();
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    for (int c = 0; c < 5; c++) begin
      mem_req_ready = (c == 4);
      pr2(S_MREQ_V, 1, "st_mreq"); pr2(S_MADDR, 32'h8000_1000, "st_maddr");
      pr2(S_MWEN, 1, "st_mwen"); pr2(S_MWDATA, 32'hDEAD_BEEF, "st_mwdata");
      pr2(S_MWMASK, 32'h0F, "st_mwmask"); pr2(S_LSU_RV, 0, "st_rv_early");
      tick();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    pr2(S_LSU_RV, 1, "st_lsu_rv"); pr2(S_IFU_RV, 0, "st_ifu_rv");
    er2(1'b1, 32'h1234_5678, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    pr2(S_BUSY, 0, "st_busy_done"); pr2(S_OWNER, 1, "st_owner_hold");
    tick();

    // Watchdog abort: memory accepts but never answers
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010; mem_rdata = 32'hFFFF_FFFF;
    pr2(S_IFU_RDY, 1, "wd_ifu_rdy");
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    pr2(S_MREQ_V, 1, "wd_mreq");
    tick();
    mem_req_ready = 1'b0;
    for (int c = 2; c < 8; c++) begin
      pr2(S_IFU_RV, 0, "wd_rv_wait"); pr2(S_ERR, 0, "wd_err_wait"); pr2(S_BUSY, 1, "wd_busy_wait");
      tick();
    end
    pr2(S_IFU_RV, 1, "wd_abort_rv"); pr2(S_ERR, 1, "wd_abort_err");
    er2(1'b0, 32'h0, 1'b1);
    tick();
    lsu_req_valid = 1'b1; lsu_addr = 32'h300; lsu_wen = 1'b0;
    pr2(S_ERR, 0, "wd_err_after"); pr2(S_BUSY, 0, "wd_busy_after"); pr2(S_LSU_RDY, 1, "wd_next_rdy");
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    pr2(S_MADDR, 32'h300, "wd_next_maddr");
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    pr2(S_LSU_RV, 1, "wd_next_rv"); er2(1'b1, 32'hCAFE_F00D, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    tick();

    // Response arriving in the would-be abort cycle wins
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
    pr2(S_IFU_RDY, 1, "late_ifu_rdy");
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (6) tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
    pr2(S_IFU_RV, 1, "late_rv"); pr2(S_ERR, 0, "late_err");
    er2(1'b0, 32'h55AA_55AA, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    pr2(S_BUSY, 0, "late_busy");
    tick();

    // Reset while in RESP, then a stray response
    lsu_req_valid = 1'b1; lsu_addr = 32'h400;
    pr2(S_LSU_RDY, 1, "mrst_lsu_rdy");
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; rst = 1'b1;
    pr2(S_LSU_RV, 0, "mrst_rv_in_rst"); pr2(S_MREQ_V, 0, "mrst_mreq_in_rst");
    tick();
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h99;
    pr2(S_IFU_RV, 0, "mrst_ifu_rv"); pr2(S_LSU_RV, 0, "mrst_lsu_rv");
    pr2(S_BUSY, 0, "mrst_busy"); pr2(S_OWNER, 0, "mrst_owner");
    tick();
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h500; lsu_addr = 32'h600;
    pr2(S_LSU_RDY, 1, "post_rst_tie_lsu"); pr2(S_IFU_RDY, 0, "post_rst_tie_ifu");
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    pr2(S_OWNER, 1, "post_rst_owner"); pr2(S_MADDR, 32'h600, "post_rst_maddr");
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h77;
    er2(1'b1, 32'h77, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    tick();
    tick();
    done = 1'b1;
  end

endmodule
